// File: rtl/cpu_pkg.sv
// Shared opcode encoding and widths for the accumulator CPU datapath.
package cpu_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    // True for the opcodes whose result is meant to be written into ac.
    function automatic logic op_is_alu(input opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction
endpackage

// File: rtl/cpu_datapath_if.sv
// Memory bus between the datapath (master) and the instruction/data memory.
interface cpu_datapath_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;

    modport master (output mem_addr, mem_wdata, mem_re, mem_we, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_re, mem_we, output mem_rdata);
endinterface

// File: rtl/cpu_alu.sv
// Combinational accumulator ALU; a = ac, b = memory read data, carry dropped.
module cpu_alu
    import cpu_pkg::*;
(
    input  opcode_e           opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = a;
        case (opcode)
            ADD:     y = a + b;
            AND:     y = a & b;
            XOR:     y = a ^ b;
            LDA:     y = b;
            default: y = a;
        endcase
    end
endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: pc/ir/ac/phase registers driven by controller strobes.
// Define CPU_DATAPATH_BUSCHK_EN to add the sticky bus_err protocol checker output.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        rd,
    input  logic        ld_ir,
    input  logic        halt,
    input  logic        inc_pc,
    input  logic        ld_ac,
    input  logic        ld_pc,
    input  logic        wr,
    input  logic        data_e,
    output logic [2:0]  phase,
    output logic [2:0]  opcode,
    output logic        zero,
`ifdef CPU_DATAPATH_BUSCHK_EN
    output logic        bus_err,
`endif
    cpu_datapath_if.master mem
);
    logic [2:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] alu_y;
    logic              stall;

    cpu_alu u_alu (
        .opcode (opcode_e'(ir_q[7:5])),
        .a      (ac_q),
        .b      (mem.mem_rdata),
        .y      (alu_y)
    );

    // Once halt is seen the machine stays frozen until rst.
    assign stall = halt | halted_q;

    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        halted_d = halted_q | halt;
        if (!stall) begin
            phase_d = phase_q + 3'd1;
            if (ld_ir) ir_d = mem.mem_rdata;
            if (ld_pc)       pc_d = ir_q[ADDR_W-1:0];
            else if (inc_pc) pc_d = pc_q + 5'd1;
            if (ld_ac) ac_d = alu_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

`ifdef CPU_DATAPATH_BUSCHK_EN
    logic bus_err_q, bus_err_d;

    // Flags a read/write collision or an ac load under a non-ALU opcode.
    always_comb begin
        bus_err_d = bus_err_q | (rd & wr) | (ld_ac & ~op_is_alu(opcode_e'(ir_q[7:5])));
    end

    always_ff @(posedge clk) begin
        if (!rst) bus_err_q <= 1'b0;
        else      bus_err_q <= bus_err_d;
    end

    assign bus_err = bus_err_q;
`endif

    assign phase         = phase_q;
    assign opcode        = ir_q[7:5];
    assign zero          = (ac_q == '0);
    assign mem.mem_addr  = sel ? pc_q : ir_q[ADDR_W-1:0];
    assign mem.mem_wdata = data_e ? ac_q : '0;
    assign mem.mem_re    = rd;
    assign mem.mem_we    = wr;
endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: directed scenarios then random strobes vs. an arithmetic model.
module tb_cpu_datapath;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [2:0] phase, opcode;
    logic zero;
`ifdef CPU_DATAPATH_BUSCHK_EN
    logic bus_err;
`endif

    cpu_datapath_if mif();

    cpu_datapath dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .wr     (wr),
        .data_e (data_e),
        .phase  (phase),
        .opcode (opcode),
        .zero   (zero),
`ifdef CPU_DATAPATH_BUSCHK_EN
        .bus_err(bus_err),
`endif
        .mem    (mif)
    );

    typedef struct {
        bit rst, sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
        int rdata;
    } stim_t;

    typedef struct {
        int phase, opcode, zero, addr, wdata, re, we, berr;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference state, plain integers
    int m_pc, m_ir, m_ac, m_ph, m_halted, m_berr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            2: return (a + b) % 256;
            3: return a & b;
            4: return a ^ b;
            5: return b;
            default: return a;
        endcase
    endfunction

    // Drive one cycle: expected outputs for the pre-edge state are queued, then the model steps.
    task automatic step(input stim_t s);
        exp_t e;
        int op;
        @(negedge clk);
        rst = s.rst; sel = s.sel; rd = s.rd; ld_ir = s.ld_ir; halt = s.halt;
        inc_pc = s.inc_pc; ld_ac = s.ld_ac; ld_pc = s.ld_pc; wr = s.wr; data_e = s.data_e;
        mif.mem_rdata = 8'(s.rdata);
        op = m_ir / 32;
        e.phase  = m_ph;
        e.opcode = op;
        e.zero   = (m_ac == 0) ? 1 : 0;
        e.addr   = s.sel ? m_pc : (m_ir % 32);
        e.wdata  = s.data_e ? m_ac : 0;
        e.re     = s.rd;
        e.we     = s.wr;
        e.berr   = m_berr;
        sb.push_back(e);
        @(posedge clk);
        if (!s.rst) begin
            m_pc = 0; m_ir = 0; m_ac = 0; m_ph = 0; m_halted = 0; m_berr = 0;
        end else begin
            if (s.rd && s.wr) m_berr = 1;
            if (s.ld_ac && !(op >= 2 && op <= 5)) m_berr = 1;
            if (!(s.halt || m_halted)) begin
                int old_ir;
                old_ir = m_ir;
                m_ph = (m_ph + 1) % 8;
                if (s.ld_ac) m_ac = alu_ref(op, m_ac, s.rdata);
                if (s.ld_ir) m_ir = s.rdata;
                if (s.ld_pc)       m_pc = old_ir % 32;
                else if (s.inc_pc) m_pc = (m_pc + 1) % 32;
            end
            if (s.halt) m_halted = 1;
        end
    endtask

    task automatic load_ir(input int v);
        stim_t s;
        s = idle(); s.ld_ir = 1; s.rdata = v;
        step(s);
    endtask

    task automatic load_ac(input int v);
        stim_t s;
        s = idle(); s.ld_ac = 1; s.rdata = v;
        step(s);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(); s.rst = 0;
        step(s);
    endtask

    // Monitor: every cycle the DUT presents outputs mid-low-phase; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("phase",     32'(phase),         e.phase);
                chk("opcode",    32'(opcode),        e.opcode);
                chk("zero",      32'(zero),          e.zero);
                chk("mem_addr",  32'(mif.mem_addr),  e.addr);
                chk("mem_wdata", 32'(mif.mem_wdata), e.wdata);
                chk("mem_re",    32'(mif.mem_re),    e.re);
                chk("mem_we",    32'(mif.mem_we),    e.we);
`ifdef CPU_DATAPATH_BUSCHK_EN
                chk("bus_err",   32'(bus_err),       e.berr);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        rst = 0; sel = 0; rd = 0; ld_ir = 0; halt = 0; inc_pc = 0;
        ld_ac = 0; ld_pc = 0; wr = 0; data_e = 0; mif.mem_rdata = '0;
        // Bring-up edge; model state defined from here on
        @(posedge clk);
        m_pc = 0; m_ir = 0; m_ac = 0; m_ph = 0; m_halted = 0; m_berr = 0;

        // Reset overrides ld_ac and halt
        s = idle(); s.rst = 0; s.ld_ac = 1; s.halt = 1; s.rdata = 8'h77;
        step(s); #1;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_opcode", 32'(opcode), 0);

        // Fetch from pc=3
        repeat (3) begin s = idle(); s.inc_pc = 1; step(s); end
        s = idle(); s.sel = 1; s.ld_ir = 1; s.rdata = 8'h4A;
        step(s); #1;
        chk("fetch_addr", 32'(mif.mem_addr), 3);
        chk("fetch_opcode", 32'(opcode), 2);

        // ALU: F0 + 20 wraps to 10, then 10 ^ 10 = 0
        load_ir(8'hA0);
        load_ac(8'hF0);
        load_ir(8'h40);
        load_ac(8'h20);
        s = idle(); s.data_e = 1; step(s); #1;
        chk("add_wrap", 32'(mif.mem_wdata), 32'h10);
        load_ir(8'h80);
        load_ac(8'h10); #1;
        chk("xor_zero", 32'(zero), 1);

        // PC wrap and ld_pc priority
        load_ir(8'hFF);
        s = idle(); s.ld_pc = 1; step(s);
        s = idle(); s.inc_pc = 1; s.sel = 1; step(s); #1;
        chk("pc_wrap", 32'(mif.mem_addr), 0);
        load_ir(8'hE9);
        s = idle(); s.ld_pc = 1; s.inc_pc = 1; s.sel = 1; step(s); #1;
        chk("pc_ldprio", 32'(mif.mem_addr), 9);

        // Store path and bus check
        load_ir(8'hA7);
        load_ac(8'h5C);
        s = idle(); s.data_e = 1; s.wr = 1; step(s); #1;
        chk("sto_addr", 32'(mif.mem_addr), 7);
        chk("sto_wdata", 32'(mif.mem_wdata), 32'h5C);
        chk("sto_we", 32'(mif.mem_we), 1);
        s = idle(); s.rd = 1; s.wr = 1; step(s);
        repeat (3) step(idle());
`ifdef CPU_DATAPATH_BUSCHK_EN
        #1;
        chk("buserr_sticky", 32'(bus_err), 1);
`endif
        do_reset();
`ifdef CPU_DATAPATH_BUSCHK_EN
        #1;
        chk("buserr_clr", 32'(bus_err), 0);
`endif

        // Halt freezes phase and pc; only reset releases it
        repeat (4) begin s = idle(); s.inc_pc = 1; step(s); end
        repeat (5) begin s = idle(); s.halt = 1; s.inc_pc = 1; s.sel = 1; step(s); end
        #1;
        chk("halt_phase", 32'(phase), 4);
        chk("halt_pc", 32'(mif.mem_addr), 4);
        do_reset(); #1;
        chk("halt_rst", 32'(phase), 0);

        // Random strobes; occasional reset keeps halts from dominating
        for (int i = 0; i < 2000; i++) begin
            s.rst    = ($urandom_range(0, 11) != 0);
            s.halt   = ($urandom_range(0, 39) == 0);
            s.sel    = 1'($urandom);
            s.rd     = 1'($urandom);
            s.wr     = ($urandom_range(0, 3) == 0);
            s.ld_ir  = 1'($urandom);
            s.inc_pc = 1'($urandom);
            s.ld_ac  = 1'($urandom);
            s.ld_pc  = ($urandom_range(0, 3) == 0);
            s.data_e = 1'($urandom);
            s.rdata  = int'($urandom_range(0, 255));
            step(s);
        end

        repeat (2) @(negedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
